// File: rtl/in_flip_fifo_rt.sv
// Ordered input buffer for FPU operand/result streams: head/tail FIFO with
// optional same-cycle bypass when empty, programmable pause threshold and sticky overflow.
module in_flip_fifo_rt #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int PAUSE_FREE = 2,
  parameter int BYPASS     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_en,
  input  logic [WIDTH-1:0]         d_in,
  output logic                     pause,
  input  logic                     dout_en,
  output logic [WIDTH-1:0]         d_out,
  output logic                     do_,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int   PTR_W  = $clog2(DEPTH);
  localparam int   CNT_W  = PTR_W + 1;
  localparam logic BYP_EN = (BYPASS != 0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = p + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem_p0 [DEPTH];
  logic [PTR_W-1:0] head_p0;
  logic [PTR_W-1:0] tail_p0;
  logic [CNT_W-1:0] count_p0;
  logic             ovf_p0;

  logic             empty;
  logic             full;
  logic [CNT_W-1:0] free;
  logic             sel_mem;
  logic             sel_byp;
  logic             vld_p0;
  logic             byp_taken;
  logic             push;
  logic             pop;
  logic             drop;
  logic [CNT_W-1:0] count_nxt;

  assign empty = (count_p0 == '0);
  assign full  = (count_p0 == CNT_W'(DEPTH));
  assign free  = CNT_W'(DEPTH) - count_p0;

  // Output qualification is forced idle while reset is held, so an in-flight
  // bypass cannot leak a transfer during reset.
  assign sel_mem = rst & ~empty;
  assign sel_byp = rst & empty & BYP_EN & in_en;
  assign vld_p0  = sel_mem | sel_byp;
  assign do_     = dout_en & vld_p0;
  assign d_out   = ({WIDTH{sel_mem}} & mem_p0[head_p0]) |
                   ({WIDTH{sel_byp}} & d_in);

  assign byp_taken = sel_byp & dout_en;
  assign push      = in_en & ~byp_taken & (~full | do_);
  assign pop       = do_ & ~empty;
  assign drop      = in_en & full & ~do_;
  assign count_nxt = count_p0 + CNT_W'(push) - CNT_W'(pop);

  assign pause = ~dout_en & (32'(free) < 32'(PAUSE_FREE));
  assign count = count_p0;
  assign ovf   = ovf_p0;

  // Stage p0: storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
      ovf_p0   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_p0[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_p0[tail_p0] <= d_in;
        tail_p0         <= ptr_inc(tail_p0);
      end
      if (pop) begin
        head_p0 <= ptr_inc(head_p0);
      end
      count_p0 <= count_nxt;
      if (drop) begin
        ovf_p0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_in_flip_fifo_rt.sv
// Directed bench for in_flip_fifo_rt: default config, a no-bypass config and a
// DEPTH=8 / PAUSE_FREE=3 config, each driven by its own scenario tasks.
module tb_in_flip_fifo_rt;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  // instance a: defaults (DEPTH=4, PAUSE_FREE=2, BYPASS=1)
  logic        in_en_a, dout_en_a, pause_a, do_a, ovf_a;
  logic [31:0] d_in_a, d_out_a;
  logic [2:0]  count_a;
  // instance b: BYPASS=0
  logic        in_en_b, dout_en_b, pause_b, do_b, ovf_b;
  logic [31:0] d_in_b, d_out_b;
  logic [2:0]  count_b;
  // instance c: DEPTH=8, PAUSE_FREE=3
  logic        in_en_c, dout_en_c, pause_c, do_c, ovf_c;
  logic [31:0] d_in_c, d_out_c;
  logic [3:0]  count_c;

  in_flip_fifo_rt u_a (
    .clk(clk), .rst(rst), .in_en(in_en_a), .d_in(d_in_a), .pause(pause_a),
    .dout_en(dout_en_a), .d_out(d_out_a), .do_(do_a), .count(count_a), .ovf(ovf_a)
  );

  in_flip_fifo_rt #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .in_en(in_en_b), .d_in(d_in_b), .pause(pause_b),
    .dout_en(dout_en_b), .d_out(d_out_b), .do_(do_b), .count(count_b), .ovf(ovf_b)
  );

  in_flip_fifo_rt #(.DEPTH(8), .PAUSE_FREE(3)) u_c (
    .clk(clk), .rst(rst), .in_en(in_en_c), .d_in(d_in_c), .pause(pause_c),
    .dout_en(dout_en_c), .d_out(d_out_c), .do_(do_c), .count(count_c), .ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_a();
    in_en_a = 1'b0; dout_en_a = 1'b0; d_in_a = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_en_a = 1'b1; dout_en_a = 1'b1; d_in_a = 32'h1234_5678;
    in_en_b = 1'b0; dout_en_b = 1'b0; d_in_b = '0;
    in_en_c = 1'b0; dout_en_c = 1'b0; d_in_c = '0;
    repeat (2) @(negedge clk);
    #2;
    vectors++;
    if (count_a !== 3'd0 || do_a !== 1'b0 || d_out_a !== 32'h0 || ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: count=%0d do_=%b d_out=%h ovf=%b, required 0 0 00000000 0",
               count_a, do_a, d_out_a, ovf_a);
    end
    @(negedge clk);
    rst = 1'b1;
    idle_a();
    repeat (2) @(negedge clk);
    #2;
    vectors++;
    if (count_a !== 3'd0 || do_a !== 1'b0 || d_out_a !== 32'h0 || ovf_a !== 1'b0 || pause_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: count=%0d do_=%b d_out=%h ovf=%b pause=%b, required idle",
               count_a, do_a, d_out_a, ovf_a, pause_a);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    in_en_a = 1'b1; dout_en_a = 1'b1; d_in_a = 32'hDEAD_BEEF;
    in_en_b = 1'b1; dout_en_b = 1'b1; d_in_b = 32'hDEAD_BEEF;
    #2;
    vectors++;
    if (do_a !== 1'b1 || d_out_a !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: do_=%b d_out=%h, required 1 deadbeef", do_a, d_out_a);
    end
    vectors++;
    if (do_b !== 1'b0 || d_out_b !== 32'h0) begin
      miscompares++;
      $display("FAIL nobypass_same_cycle: do_=%b d_out=%h, required 0 00000000", do_b, d_out_b);
    end
    @(negedge clk);
    idle_a();
    in_en_b = 1'b0; dout_en_b = 1'b0; d_in_b = '0;
    #2;
    vectors++;
    if (count_a !== 3'd0 || do_a !== 1'b0 || d_out_a !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_nothing_stored: count=%0d do_=%b d_out=%h, required 0 0 00000000",
               count_a, do_a, d_out_a);
    end
    vectors++;
    if (count_b !== 3'd1 || d_out_b !== 32'hDEAD_BEEF || do_b !== 1'b0) begin
      miscompares++;
      $display("FAIL nobypass_stored: count=%0d d_out=%h do_=%b, required 1 deadbeef 0",
               count_b, d_out_b, do_b);
    end
    @(negedge clk);
    dout_en_b = 1'b1;
    #2;
    vectors++;
    if (do_b !== 1'b1 || d_out_b !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL nobypass_pop: do_=%b d_out=%h, required 1 deadbeef", do_b, d_out_b);
    end
    @(negedge clk);
    dout_en_b = 1'b0;
    #2;
    vectors++;
    if (count_b !== 3'd0) begin
      miscompares++;
      $display("FAIL nobypass_drained: count=%0d, required 0", count_b);
    end
  endtask

  task automatic test_order_wrap();
    logic [31:0] exp_q [6];
    for (int i = 0; i < 6; i++) exp_q[i] = 32'(i + 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_en_a = 1'b1; dout_en_a = 1'b0; d_in_a = 32'(i + 1);
      #2;
      vectors++;
      if (pause_a !== (i >= 3) || do_a !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_pause[%0d]: pause=%b do_=%b, required %b 0", i, pause_a, do_a, (i >= 3));
      end
    end
    @(negedge clk);
    idle_a();
    #2;
    vectors++;
    if (count_a !== 3'd4 || pause_a !== 1'b1 || d_out_a !== 32'd1) begin
      miscompares++;
      $display("FAIL full_state: count=%0d pause=%b d_out=%h, required 4 1 00000001",
               count_a, pause_a, d_out_a);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dout_en_a = 1'b1; in_en_a = 1'b0;
      #2;
      vectors++;
      if (do_a !== 1'b1 || d_out_a !== exp_q[i]) begin
        miscompares++;
        $display("FAIL pop_first[%0d]: do_=%b d_out=%h, required 1 %h", i, do_a, d_out_a, exp_q[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dout_en_a = 1'b0; in_en_a = 1'b1; d_in_a = 32'(i + 5);
    end
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      in_en_a = 1'b0; dout_en_a = 1'b1;
      #2;
      vectors++;
      if (do_a !== 1'b1 || d_out_a !== exp_q[i]) begin
        miscompares++;
        $display("FAIL pop_wrap[%0d]: do_=%b d_out=%h, required 1 %h", i, do_a, d_out_a, exp_q[i]);
      end
    end
    @(negedge clk);
    idle_a();
    #2;
    vectors++;
    if (count_a !== 3'd0 || d_out_a !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_drained: count=%0d d_out=%h, required 0 00000000", count_a, d_out_a);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'd11; exp_q[1] = 32'd12; exp_q[2] = 32'd13; exp_q[3] = 32'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_en_a = 1'b1; dout_en_a = 1'b0; d_in_a = 32'(10 + i);
    end
    @(negedge clk);
    in_en_a = 1'b1; dout_en_a = 1'b1; d_in_a = 32'd7;
    #2;
    vectors++;
    if (do_a !== 1'b1 || d_out_a !== 32'd10 || pause_a !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pushpop: do_=%b d_out=%h pause=%b, required 1 0000000a 0",
               do_a, d_out_a, pause_a);
    end
    @(negedge clk);
    idle_a();
    #2;
    vectors++;
    if (count_a !== 3'd4 || ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pushpop_count: count=%0d ovf=%b, required 4 0", count_a, ovf_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dout_en_a = 1'b1;
      #2;
      vectors++;
      if (do_a !== 1'b1 || d_out_a !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_drain[%0d]: do_=%b d_out=%h, required 1 %h", i, do_a, d_out_a, exp_q[i]);
      end
    end
    @(negedge clk);
    idle_a();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_en_a = 1'b1; dout_en_a = 1'b0; d_in_a = 32'(20 + i);
    end
    @(negedge clk);
    in_en_a = 1'b1; dout_en_a = 1'b0; d_in_a = 32'd99;
    #2;
    vectors++;
    if (do_a !== 1'b0 || ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_before: do_=%b ovf=%b, required 0 0", do_a, ovf_a);
    end
    @(negedge clk);
    idle_a();
    #2;
    vectors++;
    if (ovf_a !== 1'b1 || count_a !== 3'd4 || d_out_a !== 32'd20) begin
      miscompares++;
      $display("FAIL ovf_set: ovf=%b count=%0d d_out=%h, required 1 4 00000014",
               ovf_a, count_a, d_out_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dout_en_a = 1'b1;
      #2;
      vectors++;
      if (d_out_a !== 32'(20 + i) || ovf_a !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_contents[%0d]: d_out=%h ovf=%b, required %h 1", i, d_out_a, ovf_a, 32'(20 + i));
      end
    end
    @(negedge clk);
    in_en_a = 1'b1; dout_en_a = 1'b0; d_in_a = 32'd55;
    @(negedge clk);
    idle_a();
    #2;
    vectors++;
    if (ovf_a !== 1'b1 || count_a !== 3'd1) begin
      miscompares++;
      $display("FAIL ovf_sticky: ovf=%b count=%0d, required 1 1", ovf_a, count_a);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (ovf_a !== 1'b0 || count_a !== 3'd0 || d_out_a !== 32'h0) begin
      miscompares++;
      $display("FAIL ovf_async_clear: ovf=%b count=%0d d_out=%h, required 0 0 00000000",
               ovf_a, count_a, d_out_a);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_pause_threshold();
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      in_en_c = (i < 6); dout_en_c = 1'b0; d_in_c = 32'(100 + i);
      #2;
      vectors++;
      if (count_c !== 4'(i) || pause_c !== (i >= 6)) begin
        miscompares++;
        $display("FAIL pause_thr[%0d]: count=%0d pause=%b, required %0d %b",
                 i, count_c, pause_c, i, (i >= 6));
      end
    end
    @(negedge clk);
    in_en_c = 1'b0; dout_en_c = 1'b1;
    #2;
    vectors++;
    if (pause_c !== 1'b0 || do_c !== 1'b1 || d_out_c !== 32'd100 || ovf_c !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_release: pause=%b do_=%b d_out=%h ovf=%b, required 0 1 00000064 0",
               pause_c, do_c, d_out_c, ovf_c);
    end
    @(negedge clk);
    dout_en_c = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_bypass();
    test_order_wrap();
    test_full_push_pop();
    test_overflow();
    test_pause_threshold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
